// File: rtl/opmode_seq_pkg.sv
// Shared types and field layout for the OPMODE micro-sequencer.
// A program entry is {last, rpt[3:0], opmode[7:0]}.
package opmode_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned OPM_LSB  = 0;
  localparam int unsigned OPM_MSB  = 7;
  localparam int unsigned RPT_LSB  = 8;
  localparam int unsigned RPT_MSB  = 11;
  localparam int unsigned LAST_BIT = 12;
  localparam int unsigned ENTRY_W  = 13;

  typedef struct packed {
    logic                       last;
    logic [RPT_MSB-RPT_LSB:0]   rpt;
    logic [OPM_MSB-OPM_LSB:0]   opmode;
  } prog_entry_t;

  // Split a raw program word into its fields.
  function automatic prog_entry_t to_entry(input logic [ENTRY_W-1:0] w);
    prog_entry_t e;
    e.last   = w[LAST_BIT];
    e.rpt    = w[RPT_MSB:RPT_LSB];
    e.opmode = w[OPM_MSB:OPM_LSB];
    return e;
  endfunction

endpackage

// File: rtl/opmode_sequencer_if.sv
// Program/control/OPMODE bundle between a controller (master) and the sequencer (slave).
interface opmode_sequencer_if #(
  parameter int unsigned AW = 3
);
  import opmode_seq_pkg::*;

  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [ENTRY_W-1:0] prog_data;
  logic               start;
  logic               abort;
  logic               advance;
  logic [7:0]         OPMODE;
  logic               CEOPMODE;
  logic               busy;
  logic               done;
  logic               prog_err;

  modport master (
    output prog_we, prog_addr, prog_data, start, abort, advance,
    input  OPMODE, CEOPMODE, busy, done, prog_err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, abort, advance,
    output OPMODE, CEOPMODE, busy, done, prog_err
  );

endinterface

// File: rtl/opmode_prog_ram.sv
// Program store: synchronous write, combinational read, contents survive reset.
module opmode_prog_ram
  import opmode_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/opmode_sequencer.sv
// Issues a stored list of OPMODE words with a CEOPMODE load strobe per entry,
// holding each entry for its programmed number of extra (advance-qualified) cycles.
module opmode_sequencer
  import opmode_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                RSTOPMODE,
  opmode_sequencer_if.slave   bus
);

  localparam logic [AW-1:0] PC_MAX = AW'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [3:0]         rcnt_q, rcnt_d;
  logic               last_q, last_d;
  logic [7:0]         opm_q, opm_d;
  logic               ce_q, ce_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               ram_we;
  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  prog_entry_t        rd_entry;

  // Writes are only accepted while idle; the read port looks ahead at the entry to load next.
  assign ram_we   = bus.prog_we && (state_q == IDLE);
  assign rd_addr  = (state_q == IDLE) ? '0 : pc_q + AW'(1);
  assign rd_entry = to_entry(rd_data);

  opmode_prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rcnt_d  = rcnt_q;
    last_d  = last_q;
    opm_d   = opm_q;
    ce_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    if (bus.prog_we && (state_q != IDLE)) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          opm_d   = rd_entry.opmode;
          rcnt_d  = rd_entry.rpt;
          last_d  = rd_entry.last;
          pc_d    = '0;
          ce_d    = 1'b1;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.advance) begin
          if (rcnt_q != 4'd0) begin
            rcnt_d = rcnt_q - 4'd1;
          end else if (last_q || (pc_q == PC_MAX)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            pc_d   = pc_q + AW'(1);
            opm_d  = rd_entry.opmode;
            rcnt_d = rd_entry.rpt;
            last_d = rd_entry.last;
            ce_d   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RSTOPMODE) begin
    if (RSTOPMODE) begin
      state_q <= IDLE;
      pc_q    <= '0;
      rcnt_q  <= 4'd0;
      last_q  <= 1'b0;
      opm_q   <= 8'h00;
      ce_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rcnt_q  <= rcnt_d;
      last_q  <= last_d;
      opm_q   <= opm_d;
      ce_q    <= ce_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.OPMODE   = opm_q;
  assign bus.CEOPMODE = ce_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.prog_err = err_q;

endmodule

// File: tb/tb_opmode_sequencer.sv
// Bench for opmode_sequencer: directed scenarios plus randomized programs and
// advance/abort patterns, compared against a slot-list model of the program.
module tb_opmode_sequencer;

  logic CLK;
  logic RSTOPMODE;
  int   total;
  int   bad;
  logic [12:0] mem_m [8];

  opmode_sequencer_if #(.AW(3)) bus ();

  opmode_sequencer #(.DEPTH(8), .AW(3)) dut (
    .CLK       (CLK),
    .RSTOPMODE (RSTOPMODE),
    .bus       (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [10:0] got_tuple();
    return {bus.OPMODE, bus.CEOPMODE, bus.busy, bus.done};
  endfunction

  task automatic write_entry(input logic [2:0] a, input logic [12:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    @(posedge CLK); #1;
    bus.prog_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic load_three();
    write_entry(3'd0, {1'b0, 4'd0, 8'h1D});
    write_entry(3'd1, {1'b0, 4'd0, 8'h3F});
    write_entry(3'd2, {1'b1, 4'd0, 8'h05});
  endtask

  // Model: the program expands into one slot per occupied cycle; every advance moves one slot on.
  task automatic run_prog(input string tag, input logic [63:0] adv_mask, input int abort_at);
    logic [7:0]  s_op[$];
    logic        s_ce[$];
    int          n_ent, idx, pulses;
    bit          fin;
    logic [7:0]  exp_op;
    logic        exp_ce, adv;
    logic [10:0] exp_t, got_t;
    n_ent = 0;
    for (int i = 0; i < 8; i++) begin
      n_ent++;
      s_op.push_back(mem_m[i][7:0]); s_ce.push_back(1'b1);
      for (int r = 0; r < int'(mem_m[i][11:8]); r++) begin
        s_op.push_back(mem_m[i][7:0]); s_ce.push_back(1'b0);
      end
      if (mem_m[i][12]) break;
    end
    bus.start = 1'b1; bus.abort = 1'b0; bus.advance = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    idx = 0; pulses = 0; fin = 0; exp_op = s_op[0];
    got_t = got_tuple(); exp_t = {exp_op, 3'b110};
    total++;
    if (got_t !== exp_t) begin bad++; $display("FAIL %s start got=%h exp=%h", tag, got_t, exp_t); end
    if (bus.CEOPMODE === 1'b1) pulses++;
    for (int c = 0; c < 300 && !fin; c++) begin
      adv = (c < 64) ? adv_mask[c] : 1'b1;
      bus.advance = adv;
      bus.abort   = (c == abort_at);
      @(posedge CLK); #1;
      got_t = got_tuple();
      if (c == abort_at) begin
        bus.abort = 1'b0;
        exp_t = {exp_op, 3'b000};
        total++;
        if (got_t !== exp_t) begin bad++; $display("FAIL %s abort c=%0d got=%h exp=%h", tag, c, got_t, exp_t); end
        fin = 1;
      end else begin
        if (adv) idx++;
        if (idx == s_op.size()) begin
          exp_t = {exp_op, 3'b001};
          total++;
          if (got_t !== exp_t) begin bad++; $display("FAIL %s done c=%0d got=%h exp=%h", tag, c, got_t, exp_t); end
          total++;
          if (pulses != n_ent) begin bad++; $display("FAIL %s pulses got=%0d exp=%0d", tag, pulses, n_ent); end
          // start during the DONE cycle must be ignored
          bus.start = 1'b1;
          @(posedge CLK); #1;
          bus.start = 1'b0;
          got_t = got_tuple(); exp_t = {exp_op, 3'b000};
          total++;
          if (got_t !== exp_t) begin bad++; $display("FAIL %s after_done got=%h exp=%h", tag, got_t, exp_t); end
          fin = 1;
        end else begin
          exp_ce = adv ? s_ce[idx] : 1'b0;
          if (adv) exp_op = s_op[idx];
          exp_t = {exp_op, exp_ce, 2'b10};
          total++;
          if (got_t !== exp_t) begin bad++; $display("FAIL %s step c=%0d got=%h exp=%h", tag, c, got_t, exp_t); end
          if (bus.CEOPMODE === 1'b1) pulses++;
        end
      end
    end
    if (!fin) begin total++; bad++; $display("FAIL %s timeout", tag); end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({got_tuple(), bus.prog_err} !== 12'h000) begin
      bad++; $display("FAIL reset got=%h exp=000", {got_tuple(), bus.prog_err});
    end
    #4 RSTOPMODE = 1'b0;
    @(posedge CLK); #1;
    total++;
    if ({got_tuple(), bus.prog_err} !== 12'h000) begin
      bad++; $display("FAIL reset_idle got=%h exp=000", {got_tuple(), bus.prog_err});
    end
  endtask

  task automatic test_three_entry();
    load_three();
    run_prog("three", '1, -1);
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (got_tuple() !== {8'h05, 3'b000}) begin
      bad++; $display("FAIL three_hold got=%h exp=%h", got_tuple(), {8'h05, 3'b000});
    end
  endtask

  task automatic test_repeat();
    write_entry(3'd0, {1'b1, 4'd3, 8'hA1});
    run_prog("rpt3", '1, -1);
  endtask

  task automatic test_stall_abort();
    load_three();
    run_prog("stall", 64'hFFFF_FFFF_FFFF_FFF9, -1);
    run_prog("abort", '1, 1);
    total++;
    if (bus.OPMODE !== 8'h3F) begin bad++; $display("FAIL abort_opm got=%h exp=3f", bus.OPMODE); end
  endtask

  task automatic test_no_last();
    for (int i = 0; i < 8; i++) write_entry(3'(i), {1'b0, 4'd0, 8'(8'h10 + i)});
    run_prog("nolast", '1, -1);
  endtask

  task automatic test_prog_err();
    load_three();
    bus.start = 1'b1; bus.advance = 1'b0;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_data = 13'h0FF;
    @(posedge CLK); #1;
    bus.prog_we = 1'b0;
    total++;
    if ({bus.prog_err, bus.busy} !== 2'b11) begin
      bad++; $display("FAIL err_set got=%b exp=11", {bus.prog_err, bus.busy});
    end
    bus.abort = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    total++;
    if ({bus.prog_err, bus.busy, bus.CEOPMODE} !== 3'b100) begin
      bad++; $display("FAIL start_abort got=%b exp=100", {bus.prog_err, bus.busy, bus.CEOPMODE});
    end
    bus.advance = 1'b1;
    run_prog("after_err", '1, -1);
    total++;
    if (bus.prog_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", bus.prog_err); end
  endtask

  task automatic test_reset_midrun();
    load_three();
    bus.start = 1'b1; bus.advance = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    #2 RSTOPMODE = 1'b1;
    #1;
    total++;
    if (got_tuple() !== 11'h000) begin bad++; $display("FAIL midrun_rst got=%h exp=000", got_tuple()); end
    #2 RSTOPMODE = 1'b0;
    @(posedge CLK); #1;
    run_prog("replay", '1, -1);
  endtask

  task automatic test_random();
    logic [63:0] m;
    int          ab;
    for (int k = 0; k < 8; k++) begin
      for (int a = 0; a < 8; a++)
        write_entry(3'(a), {($urandom_range(0, 3) == 0), 4'($urandom_range(0, 3)), 8'($urandom)});
      m  = {$urandom | $urandom, $urandom | $urandom};
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_prog("random", m, ab);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    RSTOPMODE = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = 3'd0; bus.prog_data = 13'd0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.advance = 1'b0;
    test_reset();
    test_three_entry();
    test_repeat();
    test_stall_abort();
    test_no_last();
    test_prog_err();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opmode_sequencer.md
# opmode_sequencer

Micro-sequencer that drives the OPMODE register stage of the DSP48A1 slice: it stores a short program of OPMODE words and, on command, issues them in order as an OPMODE value plus a one-cycle CEOPMODE load strobe. Each entry is held for a programmable number of extra cycles. The block sits directly upstream of the OPMODE register: its OPMODE and CEOPMODE outputs connect straight to that stage's inputs, and it shares that stage's clock and reset.

## Interface

Parameters:
- DEPTH, 8: number of program entries, power of two, range 2..16.
- AW, $clog2(DEPTH): program address width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RSTOPMODE  in  1  reset, asynchronous, active-high; clock is CLK.
- prog_we  in  1  program write strobe; honoured only in IDLE.
- prog_addr  in  AW  program write address.
- prog_data  in  13  program entry: [7:0] opmode, [11:8] rpt (extra hold cycles, 0..15), [12] last.
- start  in  1  begin execution at entry 0; honoured only in IDLE.
- abort  in  1  terminate execution; return to IDLE.
- advance  in  1  step enable; 0 stalls the sequencer.
- OPMODE  out  8  opmode presented to the OPMODE register.
- CEOPMODE  out  1  one-cycle load strobe for each new entry.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.
- prog_err  out  1  sticky; set by prog_we outside IDLE, cleared by the next accepted start.

## Operation

- States: IDLE, RUN, DONE. Internal registers: pc (AW bits), rcnt (4 bits).
- IDLE:
  - prog_we writes prog_data to mem[prog_addr].
  - On start (with abort low): OPMODE<=mem[0].opmode, CEOPMODE<=1, rcnt<=mem[0].rpt, pc<=0, prog_err<=0, go to RUN.
- RUN, advance=0: all registers hold and CEOPMODE<=0.
- RUN, advance=1:
  - If rcnt!=0: rcnt<=rcnt-1, CEOPMODE<=0.
  - Else if mem[pc].last or pc==DEPTH-1: CEOPMODE<=0, done<=1, go to DONE.
  - Else: pc<=pc+1, OPMODE<=mem[pc+1].opmode, rcnt<=mem[pc+1].rpt, CEOPMODE<=1.
- DONE: done<=0, go to IDLE. Lasts exactly one cycle and ignores start.
- abort in RUN or DONE: go to IDLE with CEOPMODE<=0 and done<=0. OPMODE holds its last value. abort has priority over every other input, including start in IDLE.
- OPMODE holds its last issued value in IDLE, so the downstream register keeps its contents.
- prog_we in RUN or DONE: no write is performed and prog_err<=1.
- start in RUN or DONE: ignored.
- Program memory is not reset. RSTOPMODE preserves its contents.

## Timing

- Reset values: OPMODE=8'h00, CEOPMODE=0, busy=0, done=0, prog_err=0, state=IDLE, pc=0, rcnt=0. The reset is asynchronous: assertion mid-run forces these values immediately, without waiting for a clock edge.
- All outputs are registered. busy is decoded from the registered state.
- Start latency: start sampled at edge k gives OPMODE=mem[0].opmode and CEOPMODE=1 in the cycle after edge k.
- With advance held at 1, entry i occupies rpt_i+1 cycles. CEOPMODE is high only in the first of those cycles.
- done is high in the cycle after the last entry's final hold cycle. busy falls in the same cycle done rises.
- Program of N entries, all rpt=0, advance=1: CEOPMODE is high for N consecutive cycles, done follows immediately, and the sequencer is back in IDLE one cycle later.
- A write at edge k is readable by a start sampled at edge k+1.

## Structure

- Package opmode_seq_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the field constants OPM_LSB=0, OPM_MSB=7, RPT_LSB=8, RPT_MSB=11, LAST_BIT=12;
  - ENTRY_W=13.
- Sub-module opmode_prog_ram: DEPTH x ENTRY_W register array with a synchronous write port and a combinational read port, no reset. The FSM, pc and rcnt live in the top level.

## Test plan

- Reset mid-run: assert RSTOPMODE during RUN, between clock edges -> OPMODE=00, CEOPMODE=0, busy=0 before the next edge; a restart then replays the preserved program.
- Three-entry program {8'h1D rpt0, 8'h3F rpt0, 8'h05 rpt0 last}, advance=1 -> CEOPMODE high three consecutive cycles with OPMODE 1D, 3F, 05; done pulse next cycle; OPMODE stays 05 in IDLE.
- Entry {8'hA1 rpt3 last}, advance=1 -> OPMODE=A1 for 4 cycles, CEOPMODE high only in the first, done in the 5th.
- Same three-entry program with advance low for 2 cycles while 3F is presented -> 3F is held 2 extra cycles and CEOPMODE does not re-pulse; with abort during 3F instead -> IDLE, no done, OPMODE stays 3F.
- No last bit in any entry, DEPTH=8 -> exactly 8 CEOPMODE pulses (pc wraps never), then done.
- prog_we during RUN -> memory unchanged and prog_err=1; next start clears prog_err; start and abort together in IDLE -> stays IDLE.
